// File: rtl/ripple_add_sub_pkg.sv
// Shared constants for the ripple-carry adder/subtractor.
package ripple_add_sub_pkg;

  localparam int   DEF_WIDTH = 4;
  localparam logic MODE_ADD  = 1'b0;
  localparam logic MODE_SUB  = 1'b1;

  // Pipeline depth from operand capture to registered result.
  localparam int   STAGES    = 1;

endpackage

// File: rtl/ripple_add_sub_full_adder.sv
// Single-bit full adder; one link of the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/ripple_add_sub.sv
// WIDTH-bit ripple-carry add/subtract with one registered result stage.
module ripple_add_sub
  import ripple_add_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
  } res_t;

  logic [WIDTH-1:0] bi;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;
  res_t             res_d;
  res_t             res_q;
  logic [STAGES:0]  vld_pipe;

  // Subtract is A + ~B + 1: invert B and feed the mode bit in as carry.
  assign bi       = b ^ {WIDTH{c == MODE_SUB}};
  assign carry[0] = (c == MODE_SUB);

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (bi[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign res_d.s    = sum;
  assign res_d.cout = carry[WIDTH];
  assign res_d.ovf  = carry[WIDTH] ^ carry[WIDTH-1];

  assign vld_pipe[0] = in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q            <= '0;
      vld_pipe[STAGES] <= 1'b0;
    end else begin
      vld_pipe[STAGES] <= vld_pipe[0];
      // Result holds while idle so downstream can keep reading it.
      if (vld_pipe[0]) res_q <= res_d;
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign s         = res_q.s;
  assign cout      = res_q.cout;
  assign ovf       = res_q.ovf;

endmodule

// File: tb/tb_ripple_add_sub.sv
// Directed + random checks of ripple_add_sub against an integer-arithmetic model.
module tb_ripple_add_sub;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic         c;
  logic         out_valid;
  logic [W-1:0] s;
  logic         cout, ovf;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] es;
  logic         ec, eo, ev;

  ripple_add_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  task automatic model(input logic [W-1:0] ta, tb, input logic tc,
                       output logic [W-1:0] rs, output logic rc, output logic ro);
    int ua, ub, sa, sb, r, sr;
    ua = int'(ta);
    ub = int'(tb);
    sa = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
    if (tc == 1'b0) begin
      r  = ua + ub;
      rc = (r >= (1 << W));
      sr = sa + sb;
    end else begin
      r  = ua - ub;
      rc = (ua >= ub);
      sr = sa - sb;
    end
    rs = W'(r);
    ro = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_s"},    32'(s),    32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"},  32'(ovf),  32'(eo));
    chk({tag, "_vld"},  32'(out_valid), 32'(ev));
  endtask

  task automatic step(input string tag, input logic [W-1:0] ta, tb,
                      input logic tc, input logic tv);
    @(negedge clk);
    a = ta; b = tb; c = tc; in_valid = tv;
    @(posedge clk);
    #1;
    if (tv) model(ta, tb, tc, es, ec, eo);
    ev = tv;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; a = 4'd9; b = 4'd9; c = 1'b0;
    es = '0; ec = 1'b0; eo = 1'b0; ev = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");

    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;

    step("add_wrap", 4'd15, 4'd15, 1'b0, 1'b1);
    chk("add_wrap_const_s", 32'(s), 32'(4'b1110));
    chk("add_wrap_const_cout", 32'(cout), 32'd1);

    step("add_ovf", 4'd7, 4'd1, 1'b0, 1'b1);
    chk("add_ovf_const_s", 32'(s), 32'(4'b1000));
    chk("add_ovf_const_ovf", 32'(ovf), 32'd1);

    step("sub_noborrow", 4'd5, 4'd3, 1'b1, 1'b1);
    chk("sub_noborrow_const_s", 32'(s), 32'(4'b0010));
    chk("sub_noborrow_const_cout", 32'(cout), 32'd1);

    step("sub_borrow", 4'd3, 4'd5, 1'b1, 1'b1);
    chk("sub_borrow_const_s", 32'(s), 32'(4'b1110));
    chk("sub_borrow_const_cout", 32'(cout), 32'd0);

    step("sub_ovf", 4'b1000, 4'd1, 1'b1, 1'b1);
    chk("sub_ovf_const_s", 32'(s), 32'(4'b0111));
    chk("sub_ovf_const_ovf", 32'(ovf), 32'd1);

    // Idle cycle with garbage operands: result must hold.
    step("hold", 4'd2, 4'd2, 1'b0, 1'b0);
    chk("hold_const_s", 32'(s), 32'(4'b0111));

    // Async reset between edges clears outputs with no clock edge.
    step("pre_rst", 4'd6, 4'd3, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    es = '0; ec = 1'b0; eo = 1'b0; ev = 1'b0;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    step("first_after_rst", 4'd1, 4'd2, 1'b0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      step("rand", W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
